ev22_fetch_seq: RTL and testbench
=================================

EV22_FETCH_SEQ -- requirements
Module: ev22_fetch_seq

Interface
REQ-001 Parameter PC_W, default 10, program-counter and ROM address width.
REQ-002 Parameter STK_DEPTH, default 4, return-stack entries.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rom_addr  output  PC_W  program ROM address.
REQ-006 rom_data  input  18  ROM word {opcode[17:10], Ri[9:5], Rj[4:0]}, valid one cycle after rom_addr.
REQ-007 OPCODE  output  8  instruction opcode to decoder.
REQ-008 Ri  output  5  instruction field Ri to decoder.
REQ-009 Rj  output  5  instruction field Rj to decoder.
REQ-010 instr_valid  output  1  OPCODE/Ri/Rj hold a new instruction this cycle.
REQ-011 stall  input  1  datapath busy; hold current instruction.
REQ-012 w_zero  input  1  working register W equals zero.
REQ-013 w15  input  1  bit 15 of W.
REQ-014 cy  input  1  carry flag.
REQ-015 stk_ovf  output  1  sticky: push attempted on full stack.
REQ-016 stk_unf  output  1  sticky: RET attempted on empty stack.

Function
REQ-017 States SHALL be FETCH, WAIT, ISSUE, EXEC; transitions FETCH->WAIT->ISSUE->EXEC->FETCH, one cycle each unless stalled.
REQ-018 FETCH: rom_addr SHALL equal PC; WAIT: ROM word captured into instruction register at end of cycle.
REQ-019 ISSUE: OPCODE/Ri/Rj SHALL reflect captured word and instr_valid=1; while stall=1, remain in ISSUE with fields held and instr_valid=1.
REQ-020 OPCODE/Ri/Rj SHALL hold their value in all states outside ISSUE; instr_valid=0 outside ISSUE.
REQ-021 EXEC SHALL sample w_zero, w15, cy and load next PC per REQ-022..REQ-027; no instruction is therefore issued more often than once per 4 cycles.
REQ-022 JMP (00100xxx): PC <= {Ri,Rj} truncated/zero-extended to PC_W.
REQ-023 JZE (00101xxx): PC <= {Ri,Rj} if w_zero=1, else PC+1; JNE (00110xxx): target if w15=0; JCY (00111xxx): target if cy=1.
REQ-024 BSR (000111xx): push PC+1; PC <= PC + sign-extended 10-bit {Ri,Rj}, modulo 2^PC_W.
REQ-025 RET (01000001): PC <= popped value.
REQ-026 All other opcodes, including NOP 00000000: PC <= PC+1, modulo 2^PC_W (0x3FF wraps to 0x000).
REQ-027 Push on full stack: oldest entry discarded, new value stored on top, stk_ovf set; branch still taken.
REQ-028 RET on empty stack: PC <= PC+1, stack unchanged, stk_unf set.
REQ-029 stk_ovf and stk_unf SHALL remain set until reset.
REQ-030 Flags are sampled only in EXEC; flag changes in other states SHALL NOT affect PC.

Reset
REQ-031 On rst_n=0, immediately: PC=0, state=FETCH, rom_addr=0, OPCODE=0, Ri=0, Rj=0, instr_valid=0, stack empty, stk_ovf=0, stk_unf=0.
REQ-032 Reset mid-instruction (any state, including stalled ISSUE) SHALL abort it with no PC or stack update; first fetch after release is address 0.
REQ-033 First rom_addr after rst_n deasserts SHALL be 0 in the first clock edge's FETCH cycle.

Structure
REQ-034 Shared package ev22_pkg SHALL hold opcode match patterns (JMP, JZE, JNE, JCY, BSR, RET, NOP), the state enum, and ROM word field positions.
REQ-035 Return stack SHALL be sub-module ev22_call_stack (push, pop, data in/out, full, empty), parameterised by STK_DEPTH and PC_W.
REQ-036 Branch decision SHALL be combinational from captured opcode and sampled flags; only PC, state, instruction register, stack and sticky flags are registered.

Verification
REQ-037 ROM 0..3 = NOP; after reset -> rom_addr sequence 0,1,2,3 at 4-cycle spacing, instr_valid one cycle per instruction.
REQ-038 ROM[5]=JZE {Ri,Rj}=0x040; w_zero=1 in EXEC -> next rom_addr 0x040; repeat with w_zero=0 -> 0x006.
REQ-039 ROM[0x010]=BSR S=0x3FE (-2), ROM[0x00E]=RET -> PC 0x010, 0x00E, 0x011; stack empty at end, no sticky flags.
REQ-040 Five nested BSR with STK_DEPTH=4 -> stk_ovf=1 after fifth; four RETs return to pushes 5,4,3,2; fifth RET -> stk_unf=1, PC+1.
REQ-041 stall=1 for 3 cycles in ISSUE -> fields stable, instr_valid=1 throughout, PC unchanged until EXEC.
REQ-042 PC=0x3FF executing NOP -> next rom_addr 0x000; rst_n pulsed low during stalled ISSUE -> outputs zero immediately, refetch from 0.

Source files
------------

// File: rtl/ev22_pkg.sv
// Shared definitions for the ev22 fetch sequencer: ROM word layout,
// opcode match patterns, sequencer states and opcode classification.
package ev22_pkg;

  localparam int unsigned WORD_W = 18;
  localparam int unsigned OPC_HI = 17;
  localparam int unsigned OPC_LO = 10;
  localparam int unsigned RI_HI  = 9;
  localparam int unsigned RI_LO  = 5;
  localparam int unsigned RJ_HI  = 4;
  localparam int unsigned RJ_LO  = 0;
  localparam int unsigned IMM_W  = 10;

  // Opcode match patterns: an opcode matches when (op & MASK) == VAL
  localparam logic [7:0] OP_JMP_VAL  = 8'b0010_0000;
  localparam logic [7:0] OP_JMP_MASK = 8'b1111_1000;
  localparam logic [7:0] OP_JZE_VAL  = 8'b0010_1000;
  localparam logic [7:0] OP_JZE_MASK = 8'b1111_1000;
  localparam logic [7:0] OP_JNE_VAL  = 8'b0011_0000;
  localparam logic [7:0] OP_JNE_MASK = 8'b1111_1000;
  localparam logic [7:0] OP_JCY_VAL  = 8'b0011_1000;
  localparam logic [7:0] OP_JCY_MASK = 8'b1111_1000;
  localparam logic [7:0] OP_BSR_VAL  = 8'b0001_1100;
  localparam logic [7:0] OP_BSR_MASK = 8'b1111_1100;
  localparam logic [7:0] OP_RET_VAL  = 8'b0100_0001;
  localparam logic [7:0] OP_RET_MASK = 8'b1111_1111;
  localparam logic [7:0] OP_NOP_VAL  = 8'b0000_0000;
  localparam logic [7:0] OP_NOP_MASK = 8'b1111_1111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    EXEC  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    K_SEQ,
    K_JMP,
    K_JZE,
    K_JNE,
    K_JCY,
    K_BSR,
    K_RET
  } op_kind_e;

  function automatic logic op_match(input logic [7:0] op,
                                    input logic [7:0] val,
                                    input logic [7:0] mask);
    return (op & mask) == val;
  endfunction

  function automatic op_kind_e op_decode(input logic [7:0] op);
    op_kind_e k;
    k = K_SEQ;
    if (op_match(op, OP_JMP_VAL, OP_JMP_MASK)) k = K_JMP;
    if (op_match(op, OP_JZE_VAL, OP_JZE_MASK)) k = K_JZE;
    if (op_match(op, OP_JNE_VAL, OP_JNE_MASK)) k = K_JNE;
    if (op_match(op, OP_JCY_VAL, OP_JCY_MASK)) k = K_JCY;
    if (op_match(op, OP_BSR_VAL, OP_BSR_MASK)) k = K_BSR;
    if (op_match(op, OP_RET_VAL, OP_RET_MASK)) k = K_RET;
    return k;
  endfunction

endpackage

// File: rtl/ev22_fetch_seq_if.sv
// ROM and decoder-side bus of the fetch sequencer.
interface ev22_fetch_seq_if
  import ev22_pkg::*;
#(
  parameter int PC_W = 10
);
  logic [PC_W-1:0]   rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [7:0]        OPCODE;
  logic [4:0]        Ri;
  logic [4:0]        Rj;
  logic              instr_valid;
  logic              stall;

  modport master (
    output rom_addr, OPCODE, Ri, Rj, instr_valid,
    input  rom_data, stall
  );

  modport slave (
    input  rom_addr, OPCODE, Ri, Rj, instr_valid,
    output rom_data, stall
  );
endinterface

// File: rtl/ev22_call_stack.sv
// Return-address stack. Entry 0 is the top; a push on a full stack
// drops the oldest (bottom) entry. Pop on empty is ignored.
module ev22_call_stack #(
  parameter int STK_DEPTH = 4,
  parameter int PC_W      = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] din_i,
  output logic [PC_W-1:0] dout_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int unsigned CNT_W = $clog2(STK_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STK_DEPTH);

  logic [PC_W-1:0]  mem_q [STK_DEPTH];
  logic [CNT_W-1:0] cnt_q;

  assign dout_o  = mem_q[0];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

  // Shift-register stack: push shifts down, pop shifts up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STK_DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      mem_q[0] <= din_i;
      for (int unsigned i = 1; i < STK_DEPTH; i++) mem_q[i] <= mem_q[i-1];
      if (cnt_q != FULL_CNT) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      for (int unsigned i = 0; i + 1 < STK_DEPTH; i++) mem_q[i] <= mem_q[i+1];
      mem_q[STK_DEPTH-1] <= '0;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: rtl/ev22_fetch_seq.sv
// Instruction fetch sequencer: FETCH -> WAIT -> ISSUE -> EXEC, with
// conditional jumps, relative subroutine calls and a return stack.
module ev22_fetch_seq
  import ev22_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int STK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ev22_fetch_seq_if.master     bus,
  input  logic                 w_zero,
  input  logic                 w15,
  input  logic                 cy,
  output logic                 stk_ovf,
  output logic                 stk_unf
);
  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic [WORD_W-1:0] ir_q;
  logic              iv_q;
  logic              ovf_q;
  logic              unf_q;

  op_kind_e          kind;
  logic [IMM_W-1:0]  imm;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   offset;
  logic              exec;
  logic              push;
  logic              pop;
  logic              unf_hit;
  logic [PC_W-1:0]   stk_dout;
  logic              stk_full;
  logic              stk_empty;

  // PC only changes at the end of EXEC, so it can drive the ROM directly
  assign bus.rom_addr    = pc_q;
  assign bus.OPCODE      = ir_q[OPC_HI:OPC_LO];
  assign bus.Ri          = ir_q[RI_HI:RI_LO];
  assign bus.Rj          = ir_q[RJ_HI:RJ_LO];
  assign bus.instr_valid = iv_q;
  assign stk_ovf         = ovf_q;
  assign stk_unf         = unf_q;

  // Next-PC and stack control from the captured opcode and live flags
  always_comb begin
    kind    = op_decode(ir_q[OPC_HI:OPC_LO]);
    imm     = ir_q[IMM_W-1:0];
    exec    = (state_q == EXEC);
    pc_inc  = pc_q + PC_W'(1);
    target  = PC_W'(imm);
    offset  = PC_W'($signed(imm));
    pc_d    = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    unf_hit = 1'b0;
    case (kind)
      K_JMP: pc_d = target;
      K_JZE: pc_d = w_zero ? target : pc_inc;
      K_JNE: pc_d = !w15   ? target : pc_inc;
      K_JCY: pc_d = cy     ? target : pc_inc;
      K_BSR: begin
        pc_d = pc_q + offset;
        push = exec;
      end
      K_RET: begin
        if (stk_empty) begin
          unf_hit = exec;
        end else begin
          pc_d = stk_dout;
          pop  = exec;
        end
      end
      default: pc_d = pc_inc;
    endcase
  end

  ev22_call_stack #(
    .STK_DEPTH (STK_DEPTH),
    .PC_W      (PC_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .dout_o  (stk_dout),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // Sequencer FSM with PC, instruction register and sticky stack flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      iv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: state_q <= WAIT;
        WAIT: begin
          ir_q    <= bus.rom_data;
          iv_q    <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          if (!bus.stall) begin
            iv_q    <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          pc_q    <= pc_d;
          ovf_q   <= ovf_q | (push & stk_full);
          unf_q   <= unf_q | unf_hit;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_ev22_fetch_seq.sv
// Directed bench for ev22_fetch_seq: sequential fetch, conditional jumps,
// call/return with overflow and underflow, stall, PC wrap, mid-run reset.
module tb_ev22_fetch_seq;
  import ev22_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_zero = 1'b0;
  logic w15 = 1'b0;
  logic cy = 1'b0;
  logic stk_ovf;
  logic stk_unf;

  int nvec = 0;
  int nerr = 0;

  logic [17:0] rom [1024];

  always #5 clk = ~clk;

  ev22_fetch_seq_if #(.PC_W(10)) bus ();

  ev22_fetch_seq #(
    .PC_W      (10),
    .STK_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .w_zero  (w_zero),
    .w15     (w15),
    .cy      (cy),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
  );

  // Synchronous ROM: data valid one cycle after the address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  function automatic logic [17:0] iw(input logic [7:0] op, input logic [9:0] imm);
    return {op, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH. Flags hold the given values
  // only during EXEC and their complements everywhere else.
  task automatic run_instr(input logic [9:0] pc, input logic wz, input logic wn,
                           input logic c, input int nstall);
    logic [17:0] word;
    word = rom[pc];
    w_zero = ~wz; w15 = ~wn; cy = ~c;
    chk("fetch_addr", 32'(bus.rom_addr), 32'(pc));
    chk("fetch_iv", 32'(bus.instr_valid), 32'd0);
    step();
    chk("wait_iv", 32'(bus.instr_valid), 32'd0);
    step();
    chk("issue_op", 32'(bus.OPCODE), 32'(word[17:10]));
    chk("issue_ri", 32'(bus.Ri), 32'(word[9:5]));
    chk("issue_rj", 32'(bus.Rj), 32'(word[4:0]));
    chk("issue_iv", 32'(bus.instr_valid), 32'd1);
    if (nstall > 0) begin
      bus.stall = 1'b1;
      for (int k = 0; k < nstall; k++) begin
        step();
        chk("stall_op", 32'(bus.OPCODE), 32'(word[17:10]));
        chk("stall_rj", 32'(bus.Rj), 32'(word[4:0]));
        chk("stall_iv", 32'(bus.instr_valid), 32'd1);
        chk("stall_addr", 32'(bus.rom_addr), 32'(pc));
      end
      bus.stall = 1'b0;
    end
    w_zero = wz; w15 = wn; cy = c;
    step();
    chk("exec_iv", 32'(bus.instr_valid), 32'd0);
    chk("exec_addr", 32'(bus.rom_addr), 32'(pc));
    chk("exec_op", 32'(bus.OPCODE), 32'(word[17:10]));
    step();
    w_zero = ~wz; w15 = ~wn; cy = ~c;
  endtask

  initial begin
    logic [17:0] w5;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[10'h005] = iw(8'h28, 10'h040);  // JZE 0x040
    rom[10'h040] = iw(8'h27, 10'h005);  // JMP 0x005
    rom[10'h006] = iw(8'h20, 10'h010);  // JMP 0x010
    rom[10'h010] = iw(8'h1C, 10'h3FE);  // BSR -2
    rom[10'h00E] = iw(8'h41, 10'h000);  // RET
    rom[10'h011] = iw(8'h30, 10'h100);  // JNE 0x100
    rom[10'h100] = iw(8'h1C, 10'h010);  // BSR +0x10
    rom[10'h110] = iw(8'h1D, 10'h010);
    rom[10'h120] = iw(8'h1F, 10'h010);
    rom[10'h130] = iw(8'h1E, 10'h010);
    rom[10'h140] = iw(8'h1C, 10'h010);
    rom[10'h150] = iw(8'h41, 10'h000);  // RET
    rom[10'h141] = iw(8'h41, 10'h000);
    rom[10'h131] = iw(8'h41, 10'h000);
    rom[10'h121] = iw(8'h41, 10'h000);
    rom[10'h111] = iw(8'h41, 10'h000);  // RET on empty stack
    rom[10'h112] = iw(8'h00, 10'h2A5);  // NOP with nonzero fields
    rom[10'h113] = iw(8'h38, 10'h3FF);  // JCY 0x3FF
    w5 = rom[10'h005];
    bus.stall = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_op", 32'(bus.OPCODE), 32'd0);
    chk("rst_iv", 32'(bus.instr_valid), 32'd0);
    chk("rst_ovf", 32'(stk_ovf), 32'd0);
    chk("rst_unf", 32'(stk_unf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 5; a++) run_instr(10'(a), 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h005, 1'b1, 1'b0, 1'b0, 0);  // taken -> 0x040
    run_instr(10'h040, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h005, 1'b0, 1'b0, 1'b0, 0);  // not taken -> 0x006
    run_instr(10'h006, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h010, 1'b0, 1'b0, 1'b0, 0);  // BSR -> 0x00E
    run_instr(10'h00E, 1'b0, 1'b0, 1'b0, 0);  // RET -> 0x011
    chk("call_ovf", 32'(stk_ovf), 32'd0);
    chk("call_unf", 32'(stk_unf), 32'd0);
    run_instr(10'h011, 1'b0, 1'b0, 1'b0, 0);  // JNE taken (w15=0)
    run_instr(10'h100, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h110, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h120, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h130, 1'b0, 1'b0, 1'b0, 0);
    chk("nest4_ovf", 32'(stk_ovf), 32'd0);
    run_instr(10'h140, 1'b0, 1'b0, 1'b0, 0);
    chk("nest5_ovf", 32'(stk_ovf), 32'd1);
    run_instr(10'h150, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h141, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h131, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h121, 1'b0, 1'b0, 1'b0, 0);
    chk("ret4_unf", 32'(stk_unf), 32'd0);
    run_instr(10'h111, 1'b0, 1'b0, 1'b0, 0);
    chk("ret5_unf", 32'(stk_unf), 32'd1);
    chk("ret5_ovf", 32'(stk_ovf), 32'd1);
    run_instr(10'h112, 1'b0, 1'b0, 1'b0, 3);  // stalled 3 cycles
    run_instr(10'h113, 1'b0, 1'b0, 1'b1, 0);  // JCY taken -> 0x3FF
    run_instr(10'h3FF, 1'b0, 1'b0, 1'b0, 0);  // NOP wraps to 0
    for (int a = 0; a < 5; a++) run_instr(10'(a), 1'b0, 1'b0, 1'b0, 0);

    // Reset during a stalled ISSUE of the JZE at 0x005
    chk("pre_addr", 32'(bus.rom_addr), 32'h005);
    step();
    step();
    chk("pre_op", 32'(bus.OPCODE), 32'(w5[17:10]));
    bus.stall = 1'b1;
    step();
    chk("pre_iv", 32'(bus.instr_valid), 32'd1);
    chk("sticky_ovf", 32'(stk_ovf), 32'd1);
    chk("sticky_unf", 32'(stk_unf), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_addr", 32'(bus.rom_addr), 32'd0);
    chk("mrst_op", 32'(bus.OPCODE), 32'd0);
    chk("mrst_ri", 32'(bus.Ri), 32'd0);
    chk("mrst_rj", 32'(bus.Rj), 32'd0);
    chk("mrst_iv", 32'(bus.instr_valid), 32'd0);
    chk("mrst_ovf", 32'(stk_ovf), 32'd0);
    chk("mrst_unf", 32'(stk_unf), 32'd0);
    bus.stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(10'h000, 1'b0, 1'b0, 1'b0, 0);
    run_instr(10'h001, 1'b0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
